// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants for the generic inter-stage pipeline register.
package pipe_stage_skid_pkg;

  // ISA-level instruction word and its bubble encoding
  localparam int unsigned ISA_IR_W   = 16;
  localparam logic [15:0] ISA_NOP_IR = 16'hF000;

  // Default data bundle: {PC, PCInc, immediate, RF operand}
  localparam int unsigned STAGE_DATA_W = 64;
  localparam int unsigned FIELD_W      = 16;
  localparam int unsigned PC_LSB       = 48;
  localparam int unsigned PCINC_LSB    = 32;
  localparam int unsigned IMM_LSB      = 16;
  localparam int unsigned RF_LSB       = 0;

  // Per-stage control widths and bubble patterns (active-low enables held at 1)
  localparam int unsigned STAGE_CTRL_W = 8;
  localparam logic [7:0]  CTRL_NOP_IF_ID  = 8'h00;
  localparam logic [7:0]  CTRL_NOP_ID_RR  = 8'h00;
  localparam logic [7:0]  CTRL_NOP_RR_EX  = 8'h00;
  localparam logic [7:0]  CTRL_NOP_EX_MEM = 8'h08;  // bit 3: write-memory enable, active low
  localparam logic [7:0]  CTRL_NOP_MEM_WB = 8'h09;  // bit 0: RF write enable, active low

  // Pack the default data bundle using the field offsets above
  function automatic logic [STAGE_DATA_W-1:0] pack_data(
    input logic [FIELD_W-1:0] pc,
    input logic [FIELD_W-1:0] pcinc,
    input logic [FIELD_W-1:0] imm,
    input logic [FIELD_W-1:0] rf
  );
    logic [STAGE_DATA_W-1:0] d;
    d = '0;
    d[PC_LSB    +: FIELD_W] = pc;
    d[PCINC_LSB +: FIELD_W] = pcinc;
    d[IMM_LSB   +: FIELD_W] = imm;
    d[RF_LSB    +: FIELD_W] = rf;
    return d;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying one pipeline entry (instruction, control, data).
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned IR_W   = ISA_IR_W,
  parameter int unsigned CTRL_W = STAGE_CTRL_W,
  parameter int unsigned DATA_W = STAGE_DATA_W
);
  logic              valid;
  logic              ready;
  logic [IR_W-1:0]   ir;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ir, output ctrl, output data, input ready);
  modport slave  (input valid, input ir, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_entry.sv
// One storage entry: valid bit plus IR/CTRL/DATA flops, loadable or clearable to a bubble.
module pipe_stage_skid_entry #(
  parameter int unsigned       IR_W     = 16,
  parameter int unsigned       CTRL_W   = 8,
  parameter int unsigned       DATA_W   = 64,
  parameter logic [IR_W-1:0]   NOP_IR   = '0,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [IR_W-1:0]   i_ir,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [IR_W-1:0]   o_ir,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [IR_W-1:0]   r_ir;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear to bubble wins over load; an invalid entry always shows the NOP pattern
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_valid <= 1'b0;
      r_ir    <= NOP_IR;
      r_ctrl  <= CTRL_NOP;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ir    <= i_ir;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ir    = r_ir;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, one-entry skid and flush-to-bubble.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       IR_W     = ISA_IR_W,
  parameter int unsigned       CTRL_W   = STAGE_CTRL_W,
  parameter int unsigned       DATA_W   = STAGE_DATA_W,
  parameter logic [IR_W-1:0]   NOP_IR   = IR_W'(ISA_NOP_IR),
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  pipe_stage_skid_if.slave   up,
  pipe_stage_skid_if.master  dn
);
  logic              w_m_valid, w_s_valid;
  logic [IR_W-1:0]   w_m_ir,    w_s_ir,    w_m_ir_d;
  logic [CTRL_W-1:0] w_m_ctrl,  w_s_ctrl,  w_m_ctrl_d;
  logic [DATA_W-1:0] w_m_data,  w_s_data,  w_m_data_d;
  logic              w_acc, w_pop;
  logic              w_m_load, w_m_clear, w_m_sel_s;
  logic              w_s_load, w_s_clear, w_s_valid_nxt;
  logic              r_in_ready;

  assign w_acc = up.valid & r_in_ready;
  assign w_pop = w_m_valid & dn.ready;

  // Main entry refills from the skid when one is parked, otherwise from the input
  assign w_m_ir_d   = w_m_sel_s ? w_s_ir   : up.ir;
  assign w_m_ctrl_d = w_m_sel_s ? w_s_ctrl : up.ctrl;
  assign w_m_data_d = w_m_sel_s ? w_s_data : up.data;

  // Entry movement decisions for this cycle
  always_comb begin
    w_m_load      = 1'b0;
    w_m_clear     = 1'b0;
    w_m_sel_s     = 1'b0;
    w_s_load      = 1'b0;
    w_s_clear     = 1'b0;
    w_s_valid_nxt = w_s_valid;
    if (flush) begin
      w_m_clear     = 1'b1;
      w_s_clear     = 1'b1;
      w_s_valid_nxt = 1'b0;
    end else if (w_s_valid && w_pop) begin
      w_m_load      = 1'b1;
      w_m_sel_s     = 1'b1;
      w_s_clear     = 1'b1;
      w_s_valid_nxt = 1'b0;
    end else if (!w_s_valid && (w_pop || !w_m_valid)) begin
      if (w_acc) begin
        w_m_load  = 1'b1;
      end else begin
        w_m_clear = 1'b1;
      end
    end else if (!w_s_valid && w_m_valid && !w_pop && w_acc) begin
      w_s_load      = 1'b1;
      w_s_valid_nxt = 1'b1;
    end
  end

  // Ready is the registered complement of next skid occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= !w_s_valid_nxt;
    end
  end

  pipe_stage_skid_entry #(
    .IR_W(IR_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_IR(NOP_IR), .CTRL_NOP(CTRL_NOP)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_ir    (w_m_ir_d),
    .i_ctrl  (w_m_ctrl_d),
    .i_data  (w_m_data_d),
    .o_valid (w_m_valid),
    .o_ir    (w_m_ir),
    .o_ctrl  (w_m_ctrl),
    .o_data  (w_m_data)
  );

  pipe_stage_skid_entry #(
    .IR_W(IR_W), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NOP_IR(NOP_IR), .CTRL_NOP(CTRL_NOP)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_s_load),
    .i_clear (w_s_clear),
    .i_ir    (up.ir),
    .i_ctrl  (up.ctrl),
    .i_data  (up.data),
    .o_valid (w_s_valid),
    .o_ir    (w_s_ir),
    .o_ctrl  (w_s_ctrl),
    .o_data  (w_s_data)
  );

  assign up.ready = r_in_ready;
  assign dn.valid = w_m_valid;
  assign dn.ir    = w_m_ir;
  assign dn.ctrl  = w_m_ctrl;
  assign dn.data  = w_m_data;
endmodule
